// File: rtl/v_result_tx_if.sv
// v_result_tx_if: groups the result buses and serial status outputs of v_result_tx.
//   v0, v1      : pipeline result registers $v0/$v1 (driven by the producer)
//   Tx          : serial line, idles high
//   Busy        : frame in flight
//   Sent        : one-cycle pulse when a frame completes
//   FrameCount  : completed frame counter, wraps at 16 bits
// modport master : producer/observer side (drives v0/v1)
// modport slave  : transmitter side (drives Tx/Busy/Sent/FrameCount)
interface v_result_tx_if;
  logic [31:0] v0;
  logic [31:0] v1;
  logic        Tx;
  logic        Busy;
  logic        Sent;
  logic [15:0] FrameCount;

  modport master (output v0, v1, input Tx, Busy, Sent, FrameCount);
  modport slave  (input v0, v1, output Tx, Busy, Sent, FrameCount);
endinterface

// File: rtl/v_result_tx.sv
// v_result_tx: watches {v1,v0}; whenever it differs from the last value sent,
// snapshots it and transmits a 9-byte 8N1 UART frame:
//   A5, v0[7:0], v0[15:8], v0[23:16], v0[31:24], v1 bytes LSB first.
// Ports:
//   Clk          : system clock, rising edge
//   Rst          : synchronous, active-low reset
//   bus (slave)  : v0/v1 in; Tx, Busy, Sent, FrameCount out (all registered)
// Parameter:
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, comparing {v1,v0} against the snapshot
// S_START | start bit (Tx=0) of byte byte_q
// S_DATA  | data bit bit_q of byte byte_q, LSB first
// S_STOP  | stop bit (Tx=1); after byte 8 the frame completes
module v_result_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  v_result_tx_if.slave  bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [63:0]   snap_q, snap_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          sent_q, sent_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    tx_byte;
  logic          baud_tc;

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [63:0] snap);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hA5;
      4'd1:    b = snap[7:0];
      4'd2:    b = snap[15:8];
      4'd3:    b = snap[23:16];
      4'd4:    b = snap[31:24];
      4'd5:    b = snap[39:32];
      4'd6:    b = snap[47:40];
      4'd7:    b = snap[55:48];
      4'd8:    b = snap[63:56];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign baud_tc = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    snap_d      = snap_q;
    frame_cnt_d = frame_cnt_q;
    sent_d      = 1'b0;
    tx_byte     = 8'hFF;
    tx_d        = 1'b1;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ({bus.v1, bus.v0} != snap_q) begin
          snap_d  = {bus.v1, bus.v0};
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      S_START: begin
        if (baud_tc) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          bit_d  = '0;
          if (byte_q < 4'd8) begin
            state_d = S_START;
            byte_d  = byte_q + 4'd1;
          end else begin
            state_d     = S_IDLE;
            byte_d      = '0;
            sent_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are derived from the next state so that they become valid on the
    // same edge that enters the state (registered, no v0/v1 to output path).
    tx_byte = frame_byte(byte_d, snap_d);
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      snap_q      <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      sent_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      snap_q      <= snap_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.Tx         = tx_q;
  assign bus.Busy       = busy_q;
  assign bus.Sent       = sent_q;
  assign bus.FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_v_result_tx.sv
module tb_v_result_tx;
  localparam int C         = 4;
  localparam int FRAME_CYC = 90 * C;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  v_result_tx_if bus();

  v_result_tx #(.CLKS_PER_BIT(C)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: frame as a 90-bit sequence ----------
  bit        m_busy = 1'b0;
  int        m_k    = 0;
  bit [63:0] m_snap = '0;
  bit        m_sent = 1'b0;
  bit [15:0] m_cnt  = '0;
  bit        m_tx   = 1'b1;
  bit        m_bits [90];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_k = 0; m_snap = '0; m_sent = 1'b0; m_cnt = '0; m_tx = 1'b1;
    end else if (m_busy) begin
      m_k++;
      if (m_k == FRAME_CYC) begin
        m_busy = 1'b0; m_sent = 1'b1; m_cnt++; m_tx = 1'b1;
      end else begin
        m_tx = m_bits[m_k / C];
      end
    end else begin
      m_sent = 1'b0;
      if ({bus.v1, bus.v0} != m_snap) begin
        m_snap = {bus.v1, bus.v0};
        for (int b = 0; b < 9; b++) begin
          bit [7:0] by;
          by = (b == 0) ? 8'hA5 : m_snap[8*(b-1) +: 8];
          m_bits[b*10] = 1'b0;
          for (int i = 0; i < 8; i++) m_bits[b*10+1+i] = by[i];
          m_bits[b*10+9] = 1'b1;
        end
        m_busy = 1'b1; m_k = 0; m_tx = m_bits[0];
      end else begin
        m_tx = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge clk) begin
    check("tx",         bus.Tx,         m_tx);
    check("busy",       bus.Busy,       m_busy);
    check("sent",       bus.Sent,       m_sent);
    check("framecount", bus.FrameCount, m_cnt);
  end

  // ---------------- line monitor / decoder ----------------------------------
  bit       tx_log[$];
  bit [7:0] last_bytes [9];
  int       last_len    = 0;
  int       busy_rises  = 0;
  int       sent_pulses = 0;
  bit       prev_busy   = 1'b0;
  bit [31:0] v0_hist[$];

  always @(negedge clk) begin
    if (bus.Busy) begin
      if (!prev_busy) begin
        tx_log.delete();
        busy_rises++;
      end
      tx_log.push_back(bus.Tx);
    end else if (prev_busy) begin
      last_len = tx_log.size();
      if (last_len == FRAME_CYC) begin
        for (int b = 0; b < 9; b++)
          for (int i = 0; i < 8; i++)
            last_bytes[b][i] = tx_log[(b*10+1+i)*C + C/2];
        v0_hist.push_back({last_bytes[4], last_bytes[3], last_bytes[2], last_bytes[1]});
      end
    end
    if (bus.Sent) sent_pulses++;
    prev_busy = bus.Busy;
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic drive(input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk); #1;
    bus.v0 = a0;
    bus.v1 = a1;
  endtask

  task automatic wait_sent(input int max_cyc, input string name);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (bus.Sent) got = 1'b1;
    end
    check(name, got, 1'b1);
    #2;
  endtask

  task automatic check_bytes(input string name, input bit [7:0] exp [9]);
    for (int b = 0; b < 9; b++) check(name, last_bytes[b], exp[b]);
  endtask

  bit [7:0] exp_b [9];
  int       pulses_before;
  bit       saw_one;

  initial begin
    bus.v0 = '0;
    bus.v1 = '0;
    rst_n  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #2;
    check("rst_tx",   bus.Tx, 1'b1);
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_sent", bus.Sent, 1'b0);
    check("rst_fc",   bus.FrameCount, 16'h0);
    repeat (1000) @(negedge clk);
    #2;
    check("idle_no_frame", busy_rises, 0);

    // Single frame
    drive(32'h12345678, 32'hDEADBEEF);
    wait_sent(FRAME_CYC + 20, "single_timeout");
    check("single_len", last_len, 360);
    exp_b = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_bytes("single_byte", exp_b);
    check("single_fc",    bus.FrameCount, 16'd1);
    check("single_pulse", sent_pulses, 1);

    // Mid-frame update
    drive(32'hAAAA0000, 32'hDEADBEEF);
    repeat (100) @(negedge clk);
    #1 bus.v0 = 32'h1;
    repeat (100) @(negedge clk);
    #1 bus.v0 = 32'h2;
    wait_sent(FRAME_CYC, "mid1_timeout");
    exp_b = '{8'hA5, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_bytes("mid_old_byte", exp_b);
    @(negedge clk); #2;
    check("mid_restart_busy", bus.Busy, 1'b1);
    wait_sent(FRAME_CYC + 5, "mid2_timeout");
    exp_b = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_bytes("mid_new_byte", exp_b);
    check("mid_fc", bus.FrameCount, 16'd3);
    saw_one = 1'b0;
    foreach (v0_hist[i]) if (v0_hist[i] == 32'h1) saw_one = 1'b1;
    check("mid_v0_1_never_sent", saw_one, 1'b0);

    // Unchanged value
    for (int r = 0; r < 5; r++) begin
      drive(32'h2, 32'hDEADBEEF);
      repeat (50) @(negedge clk);
    end
    #2;
    check("same_fc",    bus.FrameCount, 16'd3);
    check("same_rises", busy_rises, 3);

    // Reset mid-frame (inside byte 3)
    drive(32'h2, 32'h0BADF00D);
    repeat (3*10*C + 5) @(negedge clk);
    pulses_before = sent_pulses;
    #1 rst_n = 1'b0;
    @(negedge clk); #2;
    check("abort_tx",   bus.Tx, 1'b1);
    check("abort_busy", bus.Busy, 1'b0);
    check("abort_sent", bus.Sent, 1'b0);
    #1 rst_n = 1'b1;
    bus.v0 = 32'h55;
    wait_sent(FRAME_CYC + 20, "abort_resend_timeout");
    check("abort_pulses", sent_pulses, pulses_before + 1);
    check("abort_fc",     bus.FrameCount, 16'd1);
    exp_b = '{8'hA5, 8'h55, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
    check_bytes("abort_byte", exp_b);

    // FrameCount wrap
    @(negedge clk); #1;
    force dut.frame_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    pulses_before = sent_pulses;
    drive(32'h77, 32'h0BADF00D);
    wait_sent(FRAME_CYC + 20, "wrap_timeout");
    check("wrap_fc",     bus.FrameCount, 16'h0);
    check("wrap_pulses", sent_pulses, pulses_before + 1);

    // Randomized phase, checked cycle by cycle against the model
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        drive($urandom, (r < 3) ? bus.v1 : $urandom);
      end else if (r == 9) begin
        @(negedge clk); #1 rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        #1 rst_n = 1'b1;
      end else begin
        drive(bus.v0, bus.v1);
      end
      repeat ($urandom_range(1, 400)) @(negedge clk);
    end
    repeat (FRAME_CYC + 10) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
